pool_fmap_buffer: RTL and testbench
===================================

# pool_fmap_buffer

Frame buffer directly downstream of `max_pool`. It captures the six-channel pooled feature stream, one beat per valid pixel in raster order, into per-channel on-chip RAM until a full feature map is stored. It then replays the map channel-major (channel, row, column) over a valid/ready stream to feed the second convolution layer. Because `max_pool` has no backpressure, input arriving while the buffer drains is dropped and flagged.

## Interface
Parameters:
- `FMAP_W`, 14: pooled map width.
- `FMAP_H`, 14: pooled map height.
- `NUM_CH`, 6: channels per input beat.
- `DATA_W`, 8: signed feature width.

Ports:
- `i_clk`, input, 1: the single clock.
- `i_rst`, input, 1: synchronous, active-high reset.
- `i_feature_valid`, input, 1: `i_features` valid this cycle.
- `i_features`, input, `[DATA_W-1:0]` x `NUM_CH` (signed, unpacked `[0:NUM_CH-1]`): one pooled pixel for all channels.
- `o_feature_valid`, output, 1: `o_feature` holds a valid element.
- `o_feature`, output, `DATA_W` (signed): output element.
- `o_channel`, output, `$clog2(NUM_CH)`: channel index of `o_feature`.
- `o_last`, output, 1: final element of the frame (channel `NUM_CH-1`, last row, last column).
- `i_ready`, input, 1: downstream accepts when `o_feature_valid && i_ready`.
- `o_filling`, output, 1: high in FILL state.
- `o_overflow`, output, 1: sticky; an input beat was dropped.

## Operation
- Storage: `NUM_CH` RAMs of `FMAP_W*FMAP_H` x `DATA_W`, each with a synchronous 1-cycle read. RAM contents are not cleared by reset.
- Two states: FILL and DRAIN.
- FILL:
  - Each cycle with `i_feature_valid`, every channel `c` writes `i_features[c]` at `wr_addr`, then `wr_addr` increments.
  - The write at `wr_addr == FMAP_W*FMAP_H-1` moves the state to DRAIN on the next cycle and resets `wr_addr` to 0.
- DRAIN:
  - Element index `k` runs from 0 to `NUM_CH*FMAP_W*FMAP_H-1`, with channel = `k / (FMAP_W*FMAP_H)` and address = `k % (FMAP_W*FMAP_H)`.
  - `k` is tracked as separate channel and address counters, with no divider.
  - The output register loads the next element whenever it is empty or being accepted this cycle.
  - A one-entry prefetch/skid stage keeps throughput at 1 element per cycle while `i_ready` is held high.
  - Element order is strictly preserved. No element is skipped or duplicated under any `i_ready` pattern.
  - After the `o_last` element is accepted, the state returns to FILL on the next cycle with `k` cleared.
- Input during DRAIN: the beat is discarded, RAM is not written, and `o_overflow` is set. It stays set until `i_rst`.
- `o_overflow` is never set in FILL.
- The output payload (`o_feature`, `o_channel`, `o_last`) is held stable while `o_feature_valid && !i_ready`.

## Timing
- Reset values:
  - `o_feature_valid` = 0, `o_feature` = 0, `o_channel` = 0, `o_last` = 0.
  - `o_filling` = 1, `o_overflow` = 0.
  - State FILL, `wr_addr` = 0, `k` = 0.
- Reset asserted mid-FILL or mid-DRAIN takes effect on the next edge. Any partial frame is abandoned, and the output valid is dropped without completing the handshake.
- Let the final FILL write occur on edge T:
  - `o_filling` is low from T+1.
  - The first `o_feature_valid` rises at T+2 (one RAM read latency plus the output register).
- With `i_ready` constantly high, the frame is `NUM_CH*FMAP_W*FMAP_H` consecutive valid cycles. For the defaults that is 1176 cycles, from T+2 through T+1177.
- If the last element is accepted at edge E, `o_filling` is high from E+1, and a beat presented at E+1 is written at address 0.
- A valid beat in the cycle the state switches to DRAIN (the first cycle after the last write) is already a DRAIN input, so it is dropped and sets `o_overflow`.

## Configuration
- `POOL_BUF_RELU_EN`:
  - Defined: each channel value is passed through ReLU before it is written. Negative values are stored as 0, and non-negative values are unchanged.
  - Undefined: values are stored exactly as received, and signed output may be negative.
- The macro does not change write or read timing.

## Test plan
- Ramp fill: 196 beats with `i_features[c] = (n + c) & 8'h7F` for beat `n`, and `i_ready` = 1.
  - Required: 1176 outputs in channel-major order, with element (c, n) equal to `(n + c) & 8'h7F`.
  - `o_channel` steps 0..5 every 196 elements, and `o_last` is high only on the 1176th element.
- Backpressure: the same frame with `i_ready` toggled pseudo-randomly (~50%).
  - Required: an identical output sequence, and the payload is stable whenever `o_feature_valid && !i_ready`.
- Overflow: 196 beats, then 3 extra beats during DRAIN.
  - Required: `o_overflow` rises the cycle after the first extra beat and stays high.
  - The drained data is unaffected.
  - The next frame starts at address 0.
- ReLU: a frame with `i_features[c] = -5` at all addresses.
  - With `POOL_BUF_RELU_EN` defined: all outputs are 0.
  - Without it: all outputs are `8'hFB`.
- Reset mid-DRAIN: assert `i_rst` after 100 accepted outputs.
  - Required: the next cycle has `o_feature_valid` = 0 and `o_filling` = 1.
  - A fresh 196-beat frame then drains completely from element 0.
- Back-to-back frames: two frames separated only by the drain.
  - Required: the second frame's first beat is accepted the cycle after the first frame's `o_last` is accepted.
  - The second frame's output matches its own input.

Source files
------------

// File: rtl/pool_fmap_buffer.sv
// Pooled feature-map frame buffer: fills NUM_CH RAMs in raster order, then drains channel-major over valid/ready.
// Optional ReLU on write when POOL_BUF_RELU_EN is defined.
module pool_fmap_buffer #(
   parameter int FMAP_W = 14,
   parameter int FMAP_H = 14,
   parameter int NUM_CH = 6,
   parameter int DATA_W = 8
) (
   input  logic                        i_clk,
   input  logic                        i_rst,
   input  logic                        i_feature_valid,
   input  logic signed [DATA_W-1:0]    i_features [0:NUM_CH-1],
   output logic                        o_feature_valid,
   output logic signed [DATA_W-1:0]    o_feature,
   output logic [$clog2(NUM_CH)-1:0]   o_channel,
   output logic                        o_last,
   input  logic                        i_ready,
   output logic                        o_filling,
   output logic                        o_overflow
);

   localparam int DEPTH  = FMAP_W * FMAP_H;
   localparam int ADDR_W = $clog2(DEPTH);
   localparam int CH_W   = $clog2(NUM_CH);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
   localparam logic [CH_W-1:0]   LAST_CH   = CH_W'(NUM_CH - 1);

   localparam logic [0:0] ST_FILL  = 1'b0;
   localparam logic [0:0] ST_DRAIN = 1'b1;

   logic [0:0]               state;
   logic [ADDR_W-1:0]        wr_addr;
   logic [ADDR_W-1:0]        rd_addr;
   logic [CH_W-1:0]          rd_ch;
   logic                     issue_done;

   logic                     rd_vld;
   logic                     rd_last;
   logic [CH_W-1:0]          rd_ch_q;
   logic signed [DATA_W-1:0] rd_word [NUM_CH];
   logic signed [DATA_W-1:0] rd_data;

   logic                     skid_vld;
   logic                     skid_last;
   logic [CH_W-1:0]          skid_ch;
   logic signed [DATA_W-1:0] skid_data;

   logic                     wr_en;
   logic                     wr_last;
   logic                     rd_en;
   logic                     accept;
   logic                     out_free;
   logic [1:0]               occ;

   assign wr_en    = (state == ST_FILL) && i_feature_valid;
   assign wr_last  = wr_en && (wr_addr == LAST_ADDR);
   assign accept   = o_feature_valid && i_ready;
   assign out_free = !o_feature_valid || i_ready;
   assign rd_data  = rd_word[rd_ch_q];
   assign o_filling = (state == ST_FILL);

   // Elements held after this edge: output reg + skid + read in flight, minus the one leaving.
   // A new read is only issued if it is guaranteed a slot even if nothing drains next cycle.
   assign occ   = 2'(o_feature_valid) + 2'(skid_vld) + 2'(rd_vld) - 2'(accept);
   assign rd_en = wr_last || ((state == ST_DRAIN) && !issue_done && (occ <= 2'd1));

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      logic signed [DATA_W-1:0] mem [DEPTH];
      logic signed [DATA_W-1:0] wr_val;
      logic signed [DATA_W-1:0] q;

`ifdef POOL_BUF_RELU_EN
      assign wr_val = i_features[c][DATA_W-1] ? '0 : i_features[c];
`else
      assign wr_val = i_features[c];
`endif

      // NOTE: RAM contents are deliberately left out of reset so the array maps onto block RAM.
      always_ff @(posedge i_clk) begin
         if (wr_en) mem[wr_addr] <= wr_val;
         if (rd_en) q <= mem[rd_addr];
      end

      assign rd_word[c] = q;
   end

   // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state           <= ST_FILL;
         wr_addr         <= '0;
         rd_addr         <= '0;
         rd_ch           <= '0;
         issue_done      <= 1'b0;
         rd_vld          <= 1'b0;
         rd_last         <= 1'b0;
         rd_ch_q         <= '0;
         skid_vld        <= 1'b0;
         skid_last       <= 1'b0;
         skid_ch         <= '0;
         skid_data       <= '0;
         o_feature_valid <= 1'b0;
         o_feature       <= '0;
         o_channel       <= '0;
         o_last          <= 1'b0;
         o_overflow      <= 1'b0;
      end else begin
         if (wr_en) wr_addr <= wr_last ? '0 : wr_addr + ADDR_W'(1);
         if ((state == ST_DRAIN) && i_feature_valid) o_overflow <= 1'b1;

         rd_vld <= rd_en;
         if (rd_en) begin
            rd_ch_q <= rd_ch;
            rd_last <= (rd_ch == LAST_CH) && (rd_addr == LAST_ADDR);
            if (rd_addr == LAST_ADDR) begin
               rd_addr <= '0;
               if (rd_ch == LAST_CH) begin
                  rd_ch      <= '0;
                  issue_done <= 1'b1;
               end else begin
                  rd_ch <= rd_ch + CH_W'(1);
               end
            end else begin
               rd_addr <= rd_addr + ADDR_W'(1);
            end
         end

         // Oldest element first: output reg, then skid, then the RAM read data.
         if (out_free) begin
            if (skid_vld) begin
               o_feature_valid <= 1'b1;
               o_feature       <= skid_data;
               o_channel       <= skid_ch;
               o_last          <= skid_last;
               skid_vld        <= rd_vld;
               skid_data       <= rd_data;
               skid_ch         <= rd_ch_q;
               skid_last       <= rd_last;
            end else if (rd_vld) begin
               o_feature_valid <= 1'b1;
               o_feature       <= rd_data;
               o_channel       <= rd_ch_q;
               o_last          <= rd_last;
            end else begin
               o_feature_valid <= 1'b0;
            end
         end else if (rd_vld) begin
            skid_vld  <= 1'b1;
            skid_data <= rd_data;
            skid_ch   <= rd_ch_q;
            skid_last <= rd_last;
         end

         if (wr_last) begin
            state <= ST_DRAIN;
         end else if ((state == ST_DRAIN) && accept && o_last) begin
            state      <= ST_FILL;
            issue_done <= 1'b0;
            rd_addr    <= '0;
            rd_ch      <= '0;
         end
      end
   end

endmodule

// File: tb/tb_pool_fmap_buffer.sv
// Scoreboard bench for pool_fmap_buffer: stimulus pushes expected elements, a monitor pops on each handshake.
// Expected values follow POOL_BUF_RELU_EN when the macro is defined for the build.
module tb_pool_fmap_buffer;

   localparam int W = 14;
   localparam int H = 14;
   localparam int NC = 6;
   localparam int N = W * H;

   typedef struct packed {
      logic [7:0] data;
      logic [2:0] ch;
      logic       last;
   } elem_t;

   logic              i_clk;
   logic              i_rst;
   logic              i_feature_valid;
   logic signed [7:0] i_features [0:NC-1];
   logic              o_feature_valid;
   logic signed [7:0] o_feature;
   logic [2:0]        o_channel;
   logic              o_last;
   logic              i_ready;
   logic              o_filling;
   logic              o_overflow;

   pool_fmap_buffer #(.FMAP_W(W), .FMAP_H(H), .NUM_CH(NC), .DATA_W(8)) dut (
      .i_clk           (i_clk),
      .i_rst           (i_rst),
      .i_feature_valid (i_feature_valid),
      .i_features      (i_features),
      .o_feature_valid (o_feature_valid),
      .o_feature       (o_feature),
      .o_channel       (o_channel),
      .o_last          (o_last),
      .i_ready         (i_ready),
      .o_filling       (o_filling),
      .o_overflow      (o_overflow)
   );

   elem_t exp_q [$];
   int    n_cmp = 0;
   int    n_fail = 0;
   int    n_acc = 0;
   int    frames_done = 0;
   int    cyc = 0;
   int    first_cyc = 0;
   logic  rand_ready = 1'b0;
   logic  force_low = 1'b0;

   initial begin
      i_clk = 1'b0;
      forever #5 i_clk = ~i_clk;
   end

   initial forever begin
      @(posedge i_clk);
      cyc++;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      n_cmp++;
      if (act !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp_v, cyc);
      end
   endtask

   function automatic logic [7:0] beat_val(input int kind, input int n, input int c);
      case (kind)
         0:       return 8'((n + c) & 127);
         1:       return 8'(n * 3 + c * 17);
         2:       return 8'(255 - n - c * 5);
         3:       return 8'(n ^ (c << 4));
         default: return 8'hFB;
      endcase
   endfunction

   function automatic logic [7:0] stored_val(input int kind, input int n, input int c);
      logic [7:0] v;
      v = beat_val(kind, n, c);
`ifdef POOL_BUF_RELU_EN
      if (v[7]) v = 8'h00;
`endif
      return v;
   endfunction

   // Ready driver: changes just after each rising edge.
   initial begin
      i_ready = 1'b1;
      forever begin
         @(posedge i_clk);
         #1;
         if (force_low)       i_ready = 1'b0;
         else if (rand_ready) i_ready = 1'($urandom_range(0, 1));
         else                 i_ready = 1'b1;
      end
   end

   // Monitor: pops on handshakes and checks payload hold under backpressure.
   initial begin
      logic        prev_hold;
      logic [11:0] prev_payload;
      elem_t       e;
      prev_hold = 1'b0;
      prev_payload = '0;
      forever begin
         @(negedge i_clk);
         if (prev_hold && !i_rst) begin
            check("hold_valid", o_feature_valid, 1);
            check("hold_payload", {o_feature, o_channel, o_last}, prev_payload);
         end
         if (o_feature_valid && i_ready && !i_rst) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_fail++;
               $display("FAIL unexpected_output: got %0h with empty scoreboard", {o_feature, o_channel, o_last});
            end else begin
               e = exp_q.pop_front();
               check("payload", {o_feature, o_channel, o_last}, e);
               n_acc++;
               if (o_last) frames_done++;
            end
         end
         prev_hold = o_feature_valid && !i_ready && !i_rst;
         prev_payload = {o_feature, o_channel, o_last};
      end
   end

   task automatic tick();
      @(negedge i_clk);
      #1;
   endtask

   task automatic push_expected(input int kind);
      elem_t e;
      for (int c = 0; c < NC; c++) begin
         for (int n = 0; n < N; n++) begin
            e.data = stored_val(kind, n, c);
            e.ch   = 3'(c);
            e.last = (c == NC - 1) && (n == N - 1);
            exp_q.push_back(e);
         end
      end
   endtask

   // Leaves the last beat driven; the caller decides what follows it.
   task automatic drive_frame(input int kind);
      for (int n = 0; n < N; n++) begin
         tick();
         if (n == 0) check("filling_at_frame_start", o_filling, 1);
         i_feature_valid = 1'b1;
         for (int c = 0; c < NC; c++) i_features[c] = beat_val(kind, n, c);
      end
   endtask

   task automatic finish_fill();
      tick();
      i_feature_valid = 1'b0;
      check("filling_low_after_last_write", o_filling, 0);
      check("valid_not_early", o_feature_valid, 0);
      tick();
      check("first_valid_latency", o_feature_valid, 1);
      first_cyc = cyc;
   endtask

   task automatic wait_frames(input int target);
      int k;
      k = 0;
      while (frames_done < target && k < 5000) begin
         tick();
         k++;
      end
      if (frames_done < target) begin
         n_cmp++;
         n_fail++;
         $display("FAIL drain_timeout: frames %0d expected %0d", frames_done, target);
      end
   endtask

   initial begin
      int target;
      int base;
      int k;
      #1_000_000;
      $display("FAIL global_timeout: bench did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int target;
      int base;
      int k;
      target = 0;
      i_rst = 1'b1;
      i_feature_valid = 1'b0;
      for (int c = 0; c < NC; c++) i_features[c] = '0;
      repeat (3) tick();
      check("rst_valid", o_feature_valid, 0);
      check("rst_feature", o_feature, 0);
      check("rst_channel", o_channel, 0);
      check("rst_last", o_last, 0);
      check("rst_filling", o_filling, 1);
      check("rst_overflow", o_overflow, 0);
      i_rst = 1'b0;
      tick();

      // Ramp frame, ready held high: 1176 back-to-back valid cycles.
      push_expected(0);
      drive_frame(0);
      finish_fill();
      wait_frames(++target);
      check("drain_cycles", cyc - first_cyc, N * NC - 1);
      check("no_overflow_ramp", o_overflow, 0);

      // Same frame under random backpressure.
      rand_ready = 1'b1;
      push_expected(0);
      drive_frame(0);
      finish_fill();
      wait_frames(++target);
      rand_ready = 1'b0;

      // Back-to-back frames: second frame's first beat right after o_last is accepted.
      push_expected(1);
      push_expected(2);
      drive_frame(1);
      finish_fill();
      wait_frames(++target);
      drive_frame(2);
      finish_fill();
      check("no_overflow_b2b", o_overflow, 0);
      wait_frames(++target);

      // Overflow: three beats while draining.
      push_expected(3);
      drive_frame(3);
      tick();
      for (int c = 0; c < NC; c++) i_features[c] = 8'h55;
      check("overflow_before_extra", o_overflow, 0);
      tick();
      check("overflow_rise", o_overflow, 1);
      check("first_valid_latency_ovf", o_feature_valid, 1);
      for (int c = 0; c < NC; c++) i_features[c] = 8'h66;
      tick();
      for (int c = 0; c < NC; c++) i_features[c] = 8'h77;
      tick();
      i_feature_valid = 1'b0;
      check("overflow_sticky", o_overflow, 1);
      wait_frames(++target);
      push_expected(0);
      drive_frame(0);
      finish_fill();
      wait_frames(++target);
      check("overflow_kept", o_overflow, 1);

      // Reset mid-drain after 100 accepted outputs.
      push_expected(2);
      drive_frame(2);
      finish_fill();
      base = n_acc;
      k = 0;
      while (n_acc - base < 100 && k < 1000) begin
         tick();
         k++;
      end
      check("accepted_before_reset", n_acc - base, 100);
      force_low = 1'b1;
      tick();
      i_rst = 1'b1;
      tick();
      check("reset_drops_valid", o_feature_valid, 0);
      check("reset_filling", o_filling, 1);
      check("reset_clears_overflow", o_overflow, 0);
      i_rst = 1'b0;
      exp_q.delete();
      force_low = 1'b0;
      push_expected(1);
      drive_frame(1);
      finish_fill();
      wait_frames(++target);

      // Negative input: ReLU clamps to 0 when enabled, otherwise stored as-is.
      push_expected(5);
      drive_frame(5);
      finish_fill();
      wait_frames(++target);

      repeat (4) tick();
      check("scoreboard_empty", exp_q.size(), 0);
      check("valid_idle_at_end", o_feature_valid, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
